// File: rtl/lfsr_roller.sv
// Dice-roll generator: Galois LFSR stepped on a linearly slowing cadence, with a recallable
// ring history of finished rolls. Define LFSR_ROLLER_SKIP_EN to let i_start in RUN end the roll early.
module lfsr_roller #(
  parameter int unsigned          LFSR_W      = 16,
  parameter logic [LFSR_W-1:0]    TAPS        = 16'hB400,
  parameter int unsigned          OUT_W       = 4,
  parameter int unsigned          DEPTH       = 16,
  parameter int unsigned          STEPS       = 16,
  parameter int unsigned          BASE_PERIOD = 2097152,
  parameter int unsigned          PERIOD_W    = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_seed_valid,
  input  logic [LFSR_W-1:0]          i_seed,
  input  logic                       i_recall,
  input  logic [$clog2(DEPTH)-1:0]   i_recall_idx,
  output logic [OUT_W-1:0]           o_random_out,
  output logic [OUT_W-1:0]           o_stored_out,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned STEP_W = $clog2(STEPS + 1);
  localparam logic [PERIOD_W-1:0] BASE      = PERIOD_W'(BASE_PERIOD);
  localparam logic [STEP_W-1:0]   LAST_STEP = STEP_W'(STEPS - 1);
  localparam logic [IDX_W:0]      COUNT_MAX = (IDX_W + 1)'(DEPTH);

  typedef enum logic {StIdle, StRun} state_e;

  state_e              r_state, w_state_nxt;
  logic [LFSR_W-1:0]   r_lfsr, w_lfsr_nxt;
  logic [LFSR_W-1:0]   r_seed_cnt;
  logic [PERIOD_W-1:0] r_timer, w_timer_nxt;
  logic [PERIOD_W-1:0] r_limit, w_limit_nxt;
  logic [STEP_W-1:0]   r_step, w_step_nxt;
  logic [OUT_W-1:0]    r_out, w_out_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic [OUT_W-1:0]    r_hist [DEPTH];
  logic [IDX_W-1:0]    r_wptr;
  logic [IDX_W:0]      r_count;
  logic [OUT_W-1:0]    r_stored;

  logic [LFSR_W-1:0]   w_seed_raw, w_seed, w_lfsr_adv;
  logic [PERIOD_W-1:0] w_timer_inc;
  logic                w_sched, w_advance, w_last, w_hist_we, w_skip;
  logic [IDX_W-1:0]    w_rd_ptr;

  assign w_seed_raw  = i_seed_valid ? i_seed : r_seed_cnt;
  assign w_seed      = (w_seed_raw == '0) ? LFSR_W'(1) : w_seed_raw;
  assign w_lfsr_adv  = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
  assign w_timer_inc = r_timer + PERIOD_W'(1);
  assign w_sched     = (w_timer_inc == r_limit);

`ifdef LFSR_ROLLER_SKIP_EN
  logic r_skip, w_skip_nxt;
  assign w_skip = r_skip;
`else
  assign w_skip = 1'b0;
`endif

  // A pending skip and a scheduled advance on the same edge collapse into one advance.
  assign w_advance = (r_state == StRun) && (w_sched || w_skip);
  assign w_last    = w_advance && ((r_step == LAST_STEP) || w_skip);

  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_timer_nxt = r_timer;
    w_limit_nxt = r_limit;
    w_step_nxt  = r_step;
    w_out_nxt   = r_out;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_hist_we   = 1'b0;
`ifdef LFSR_ROLLER_SKIP_EN
    w_skip_nxt  = r_skip;
`endif
    case (r_state)
      StIdle: begin
`ifdef LFSR_ROLLER_SKIP_EN
        w_skip_nxt = 1'b0;
`endif
        if (i_start) begin
          w_state_nxt = StRun;
          w_lfsr_nxt  = w_seed;
          w_out_nxt   = w_seed[OUT_W-1:0];
          w_busy_nxt  = 1'b1;
          w_timer_nxt = '0;
          w_step_nxt  = '0;
          w_limit_nxt = BASE;
        end
      end
      StRun: begin
        w_timer_nxt = w_timer_inc;
`ifdef LFSR_ROLLER_SKIP_EN
        if (i_start) w_skip_nxt = 1'b1;
`endif
        if (w_advance) begin
          w_lfsr_nxt  = w_lfsr_adv;
          w_out_nxt   = w_lfsr_adv[OUT_W-1:0];
          w_timer_nxt = '0;
          w_step_nxt  = r_step + STEP_W'(1);
          w_limit_nxt = r_limit + BASE;
          if (w_last) begin
            w_state_nxt = StIdle;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_hist_we   = 1'b1;
`ifdef LFSR_ROLLER_SKIP_EN
            w_skip_nxt  = 1'b0;
`endif
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_lfsr     <= LFSR_W'(1);
      r_seed_cnt <= '0;
      r_timer    <= '0;
      r_limit    <= '0;
      r_step     <= '0;
      r_out      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef LFSR_ROLLER_SKIP_EN
      r_skip     <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_lfsr     <= w_lfsr_nxt;
      r_seed_cnt <= r_seed_cnt + LFSR_W'(1);
      r_timer    <= w_timer_nxt;
      r_limit    <= w_limit_nxt;
      r_step     <= w_step_nxt;
      r_out      <= w_out_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
`ifdef LFSR_ROLLER_SKIP_EN
      r_skip     <= w_skip_nxt;
`endif
    end
  end

  // Index 0 is the newest entry, i.e. the slot just behind the write pointer.
  assign w_rd_ptr = r_wptr - IDX_W'(1) - i_recall_idx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_hist[i] <= '0;
      r_wptr   <= '0;
      r_count  <= '0;
      r_stored <= '0;
    end else begin
      if (w_hist_we) begin
        r_hist[r_wptr] <= w_lfsr_adv[OUT_W-1:0];
        r_wptr         <= r_wptr + IDX_W'(1);
        if (r_count != COUNT_MAX) r_count <= r_count + (IDX_W + 1)'(1);
      end
      if (i_recall) begin
        r_stored <= ({1'b0, i_recall_idx} < r_count) ? r_hist[w_rd_ptr] : '0;
      end
    end
  end

  assign o_random_out = r_out;
  assign o_stored_out = r_stored;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_count      = r_count;

endmodule

// File: tb/tb_lfsr_roller.sv
// Directed bench for lfsr_roller with BASE_PERIOD=2, STEPS=4, DEPTH=4.
module tb_lfsr_roller;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_seed_valid;
  logic [15:0] i_seed;
  logic        i_recall;
  logic [1:0]  i_recall_idx;
  logic [3:0]  o_random_out;
  logic [3:0]  o_stored_out;
  logic        o_busy;
  logic        o_done;
  logic [2:0]  o_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  lfsr_roller #(
    .BASE_PERIOD(2),
    .STEPS(4),
    .DEPTH(4)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_start(i_start),
    .i_seed_valid(i_seed_valid),
    .i_seed(i_seed),
    .i_recall(i_recall),
    .i_recall_idx(i_recall_idx),
    .o_random_out(o_random_out),
    .o_stored_out(o_stored_out),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_count(o_count)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    i_start = 1'b0; i_seed_valid = 1'b0; i_seed = '0; i_recall = 1'b0; i_recall_idx = '0;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic do_roll(input logic [15:0] seed);
    int waited;
    i_seed = seed; i_seed_valid = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_seed_valid = 1'b0;
    waited = 0;
    while (o_done !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    n_checks++;
    if (o_done !== 1'b1) begin
      n_fail++;
      $display("FAIL roll_timeout seed=%h: o_done=%b want 1", seed, o_done);
    end
  endtask

  task automatic recall(input logic [1:0] idx);
    i_recall = 1'b1; i_recall_idx = idx;
    tick();
    i_recall = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_start = 1'b0; i_seed_valid = 1'b0; i_seed = '0; i_recall = 1'b0; i_recall_idx = '0;
    #1;
    n_checks++;
    if ({o_random_out, o_stored_out, o_busy, o_done, o_count} !== '0) begin
      n_fail++;
      $display("FAIL por_outputs: out=%h stored=%h busy=%b done=%b count=%0d want all 0",
               o_random_out, o_stored_out, o_busy, o_done, o_count);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  // Counter is 0 on the first edge after reset, so the 20th edge samples seed 0x0013.
  task automatic test_free_seed();
    apply_reset();
    repeat (19) tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_checks++;
    if (o_random_out !== 4'h3) begin
      n_fail++;
      $display("FAIL free_seed_start: out=%h want 3", o_random_out);
    end
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 20) begin
        n_checks++;
        if (o_done !== 1'b1 || o_random_out !== 4'h1) begin
          n_fail++;
          $display("FAIL free_seed_final: done=%b out=%h want 1 1", o_done, o_random_out);
        end
      end
    end
  endtask

  task automatic test_roll();
    logic [3:0] exp_out;
    apply_reset();
    i_seed = 16'h0006; i_seed_valid = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_seed_valid = 1'b0;
    n_checks++;
    if (o_random_out !== 4'h6 || o_busy !== 1'b1 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL roll_edge0: out=%h busy=%b done=%b want 6 1 0", o_random_out, o_busy, o_done);
    end
    for (int e = 1; e <= 21; e++) begin
      tick();
      exp_out = (e < 2) ? 4'h6 : (e < 6) ? 4'h3 : (e < 12) ? 4'h1 : 4'h0;
      n_checks++;
      if (o_random_out !== exp_out || o_busy !== (e < 20) || o_done !== (e == 20)) begin
        n_fail++;
        $display("FAIL roll_edge%0d: out=%h busy=%b done=%b want %h %b %b", e, o_random_out,
                 o_busy, o_done, exp_out, (e < 20), (e == 20));
      end
    end
    n_checks++;
    if (o_count !== 3'd1) begin
      n_fail++;
      $display("FAIL roll_count: count=%0d want 1", o_count);
    end
  endtask

  task automatic test_zero_seed();
    logic [3:0] exp_out;
    apply_reset();
    i_seed = 16'h0000; i_seed_valid = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_seed_valid = 1'b0;
    n_checks++;
    if (o_random_out !== 4'h1) begin
      n_fail++;
      $display("FAIL zero_seed_start: out=%h want 1", o_random_out);
    end
    for (int e = 1; e <= 20; e++) begin
      tick();
      exp_out = (e < 2) ? 4'h1 : 4'h0;
      n_checks++;
      if (o_random_out !== exp_out || o_done !== (e == 20)) begin
        n_fail++;
        $display("FAIL zero_seed_edge%0d: out=%h done=%b want %h %b", e, o_random_out, o_done,
                 exp_out, (e == 20));
      end
    end
  endtask

  // Seeds with a zero low nibble never hit a tap in four shifts: final = seed[7:4].
  task automatic test_history();
    logic [3:0]  exp_part [4];
    logic [3:0]  exp_full [4];
    logic [15:0] seeds [5];
    exp_part = '{4'h2, 4'h1, 4'h0, 4'h0};
    exp_full = '{4'h5, 4'h4, 4'h3, 4'h2};
    seeds    = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050};
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      do_roll(seeds[r]);
      n_checks++;
      if (o_random_out !== 4'(r + 1)) begin
        n_fail++;
        $display("FAIL hist_final%0d: out=%h want %h", r, o_random_out, 4'(r + 1));
      end
    end
    n_checks++;
    if (o_count !== 3'd2) begin
      n_fail++;
      $display("FAIL hist_count2: count=%0d want 2", o_count);
    end
    for (int k = 0; k < 4; k++) begin
      recall(2'(k));
      n_checks++;
      if (o_stored_out !== exp_part[k]) begin
        n_fail++;
        $display("FAIL hist_part_idx%0d: stored=%h want %h", k, o_stored_out, exp_part[k]);
      end
    end
    recall(2'd0);
    i_recall_idx = 2'd1;
    tick();
    n_checks++;
    if (o_stored_out !== 4'h2) begin
      n_fail++;
      $display("FAIL hist_hold: stored=%h want 2", o_stored_out);
    end
    for (int r = 2; r < 5; r++) begin
      do_roll(seeds[r]);
      n_checks++;
      if (o_count !== ((r == 2) ? 3'd3 : 3'd4)) begin
        n_fail++;
        $display("FAIL hist_count_roll%0d: count=%0d want %0d", r, o_count, (r == 2) ? 3 : 4);
      end
    end
    for (int k = 0; k < 4; k++) begin
      recall(2'(k));
      n_checks++;
      if (o_stored_out !== exp_full[k]) begin
        n_fail++;
        $display("FAIL hist_full_idx%0d: stored=%h want %h", k, o_stored_out, exp_full[k]);
      end
    end
  endtask

  task automatic test_start_in_run();
    logic [3:0] exp_out;
    int         last_e;
`ifdef LFSR_ROLLER_SKIP_EN
    last_e = 4;
`else
    last_e = 20;
`endif
    apply_reset();
    i_seed = 16'h0006; i_seed_valid = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_seed_valid = 1'b0;
    for (int e = 1; e <= last_e; e++) begin
      i_start = (e == 3);
      tick();
      i_start = 1'b0;
`ifdef LFSR_ROLLER_SKIP_EN
      exp_out = (e < 2) ? 4'h6 : (e < 4) ? 4'h3 : 4'h1;
`else
      exp_out = (e < 2) ? 4'h6 : (e < 6) ? 4'h3 : (e < 12) ? 4'h1 : 4'h0;
`endif
      n_checks++;
      if (o_random_out !== exp_out || o_busy !== (e < last_e) || o_done !== (e == last_e)) begin
        n_fail++;
        $display("FAIL start_in_run_edge%0d: out=%h busy=%b done=%b want %h %b %b", e,
                 o_random_out, o_busy, o_done, exp_out, (e < last_e), (e == last_e));
      end
    end
  endtask

  task automatic test_recall_on_done();
    apply_reset();
    do_roll(16'h0030);
    i_seed = 16'h0050; i_seed_valid = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_seed_valid = 1'b0;
    repeat (19) tick();
    i_recall = 1'b1; i_recall_idx = 2'd0;
    tick();
    n_checks++;
    if (o_done !== 1'b1 || o_stored_out !== 4'h3) begin
      n_fail++;
      $display("FAIL recall_on_done: done=%b stored=%h want 1 3", o_done, o_stored_out);
    end
    tick();
    i_recall = 1'b0;
    n_checks++;
    if (o_stored_out !== 4'h5) begin
      n_fail++;
      $display("FAIL recall_after_done: stored=%h want 5", o_stored_out);
    end
  endtask

  task automatic test_reset_mid();
    i_seed = 16'h0006; i_seed_valid = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_seed_valid = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (o_busy !== 1'b1 || o_stored_out !== 4'h5) begin
      n_fail++;
      $display("FAIL pre_reset_state: busy=%b stored=%h want 1 5", o_busy, o_stored_out);
    end
    #2;
    i_rst = 1'b1;
    #1;
    n_checks++;
    if ({o_random_out, o_stored_out, o_busy, o_done, o_count} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: out=%h stored=%h busy=%b done=%b count=%0d want all 0",
               o_random_out, o_stored_out, o_busy, o_done, o_count);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    recall(2'd0);
    n_checks++;
    if (o_stored_out !== 4'h0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: stored=%h busy=%b want 0 0", o_stored_out, o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_free_seed();
    test_roll();
    test_zero_seed();
    test_history();
    test_start_in_run();
    test_recall_on_done();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
